// File: rtl/aclk_set_ctrl_pkg.sv
// Shared types for the alarm clock setting controller.
// Holds FSM/target encodings and the packed BCD hh:mm bundle.
package aclk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EDIT_H,
        EDIT_M,
        COMMIT
    } state_e;

    typedef enum logic {
        TIME,
        ALARM
    } target_e;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } bcd_hm_t;

    localparam int MAX_H1      = 2;
    localparam int MAX_H0_AT_2 = 3;
    localparam int MAX_M1      = 5;

    localparam logic [4:0] HR_WRAP  = 5'(MAX_H1 * 10 + MAX_H0_AT_2 + 1);
    localparam logic [6:0] MIN_WRAP = 7'((MAX_M1 + 1) * 10);

endpackage

// File: rtl/aclk_set_ctrl_if.sv
// Front-panel / clock-core bundle for aclk_set_ctrl.
// master drives buttons and current time; slave is the controller.
interface aclk_set_ctrl_if;

    logic       btn_set_time;
    logic       btn_set_alarm;
    logic       btn_inc;
    logic       btn_next;
    logic       btn_al_toggle;
    logic       btn_stop;
    logic       Alarm;
    logic [1:0] H_out1;
    logic [3:0] H_out0;
    logic [3:0] M_out1;
    logic [3:0] M_out0;

    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       STOP_al;
    logic       AL_ON;
    logic       editing;
    logic       edit_field;

    modport master (
        output btn_set_time, btn_set_alarm, btn_inc, btn_next,
        output btn_al_toggle, btn_stop, Alarm,
        output H_out1, H_out0, M_out1, M_out0,
        input  H_in1, H_in0, M_in1, M_in0,
        input  LD_time, LD_alarm, STOP_al, AL_ON,
        input  editing, edit_field
    );

    modport slave (
        input  btn_set_time, btn_set_alarm, btn_inc, btn_next,
        input  btn_al_toggle, btn_stop, Alarm,
        input  H_out1, H_out0, M_out1, M_out0,
        output H_in1, H_in0, M_in1, M_in0,
        output LD_time, LD_alarm, STOP_al, AL_ON,
        output editing, edit_field
    );

endinterface

// File: rtl/aclk_bcd_inc.sv
// Combinational BCD hh:mm adder: adds 0..59 minutes and/or one hour.
// carry_en lets minute overflow ripple into hours (snooze) or not (edit).
module aclk_bcd_inc
    import aclk_pkg::*;
(
    input  bcd_hm_t    a,
    input  logic [5:0] add_min,
    input  logic       add_hr,
    input  logic       carry_en,
    output bcd_hm_t    y
);

    logic [6:0] m_bin;
    logic [6:0] m_sum;
    logic [6:0] m_wrap;
    logic       m_cy;
    logic [4:0] h_bin;
    logic [4:0] h_sum;
    logic [4:0] h_wrap;

    always_comb begin
        m_bin  = 7'(a.m1) * 7'd10 + 7'(a.m0);
        m_sum  = m_bin + 7'(add_min);
        m_cy   = (m_sum >= MIN_WRAP);
        m_wrap = m_cy ? (m_sum - MIN_WRAP) : m_sum;

        h_bin  = 5'(a.h1) * 5'd10 + 5'(a.h0);
        h_sum  = h_bin + 5'(add_hr) + 5'(m_cy & carry_en);
        h_wrap = (h_sum >= HR_WRAP) ? (h_sum - HR_WRAP) : h_sum;

        y.m1 = 4'(m_wrap / 7'd10);
        y.m0 = 4'(m_wrap % 7'd10);
        y.h1 = 2'(h_wrap / 5'd10);
        y.h0 = 4'(h_wrap % 5'd10);
    end

endmodule

// File: rtl/aclk_set_ctrl.sv
// Button-driven time/alarm setting controller (10 Hz domain).
// Optional snooze reload on stop is enabled by ACLK_SNOOZE_EN.
module aclk_set_ctrl
    import aclk_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 300,
    parameter int STOP_CYCLES   = 2,
    parameter int SNOOZE_MIN    = 5
) (
    input logic            clk,
    input logic            reset_n,
    aclk_set_ctrl_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam int SW = $clog2(STOP_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);
    localparam logic [SW-1:0] STOP_LEN = SW'(STOP_CYCLES);

    state_e        state_q, state_d;
    target_e       tgt_q, tgt_d;
    bcd_hm_t       edit_q, edit_d;
    bcd_hm_t       shadow_q, shadow_d;
    logic [TW-1:0] to_q, to_d;
    logic [SW-1:0] stop_q, stop_d;
    logic          al_on_q, al_on_d;

    bcd_hm_t    h_out;
    bcd_hm_t    inc_a;
    bcd_hm_t    inc_y;
    logic [5:0] inc_min;
    logic       inc_hr;
    logic       inc_cy;

    logic any_btn;
    logic w_set_t, w_set_a, w_next, w_inc, w_tog;
    logic editing;
    logic edit_start;
    logic snz_go;
    logic snz_fire;

    assign h_out = '{h1: bus.H_out1, h0: bus.H_out0,
                     m1: bus.M_out1, m0: bus.M_out0};

    assign any_btn = bus.btn_set_time | bus.btn_set_alarm
                   | bus.btn_inc | bus.btn_next
                   | bus.btn_al_toggle | bus.btn_stop;

    // One-hot winner; lower-priority pulses in the same cycle are dropped
    assign w_set_t = bus.btn_set_time;
    assign w_set_a = bus.btn_set_alarm & ~w_set_t;
    assign w_next  = bus.btn_next & ~(bus.btn_set_time | bus.btn_set_alarm);
    assign w_inc   = bus.btn_inc & ~(bus.btn_set_time | bus.btn_set_alarm
                                   | bus.btn_next);
    assign w_tog   = bus.btn_al_toggle
                   & ~(bus.btn_set_time | bus.btn_set_alarm
                     | bus.btn_next | bus.btn_inc);

    assign editing    = (state_q == EDIT_H) || (state_q == EDIT_M);
    assign edit_start = (state_q == IDLE)
                      & (bus.btn_set_time | bus.btn_set_alarm);

    always_comb begin
        inc_a   = edit_q;
        inc_min = '0;
        inc_hr  = 1'b0;
        inc_cy  = 1'b0;
        if (snz_go) begin
            inc_a   = h_out;
            inc_min = 6'(SNOOZE_MIN);
            inc_cy  = 1'b1;
        end else if (state_q == EDIT_H) begin
            inc_hr = 1'b1;
        end else if (state_q == EDIT_M) begin
            inc_min = 6'd1;
        end
    end

    aclk_bcd_inc u_inc (
        .a        (inc_a),
        .add_min  (inc_min),
        .add_hr   (inc_hr),
        .carry_en (inc_cy),
        .y        (inc_y)
    );

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        edit_d   = edit_q;
        shadow_d = shadow_q;
        al_on_d  = al_on_q;
        case (state_q)
            IDLE: begin
                unique case (1'b1)
                    w_set_t: begin
                        state_d = EDIT_H;
                        tgt_d   = TIME;
                        edit_d  = h_out;
                    end
                    w_set_a: begin
                        state_d = EDIT_H;
                        tgt_d   = ALARM;
                        edit_d  = shadow_q;
                    end
                    w_tog:   al_on_d = ~al_on_q;
                    default: ;
                endcase
            end
            EDIT_H, EDIT_M: begin
                unique case (1'b1)
                    w_next: state_d = (state_q == EDIT_H) ? EDIT_M : COMMIT;
                    w_inc:  edit_d  = inc_y;
                    default: begin
                        if (!any_btn && to_q == TO_LAST) begin
                            state_d = IDLE;
                        end
                    end
                endcase
            end
            COMMIT: begin
                state_d = IDLE;
                if (tgt_q == ALARM) begin
                    shadow_d = edit_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (snz_go) begin
            edit_d = inc_y;
        end
    end

    always_comb begin
        to_d = to_q + TW'(1);
        if (any_btn || !editing || state_d != state_q) begin
            to_d = '0;
        end
        stop_d = (stop_q != '0) ? stop_q - SW'(1) : '0;
        if (bus.btn_stop) begin
            stop_d = STOP_LEN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            tgt_q    <= TIME;
            edit_q   <= '0;
            shadow_q <= '0;
            to_q     <= '0;
            stop_q   <= '0;
            al_on_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            edit_q   <= edit_d;
            shadow_q <= shadow_d;
            to_q     <= to_d;
            stop_q   <= stop_d;
            al_on_q  <= al_on_d;
        end
    end

`ifdef ACLK_SNOOZE_EN
    logic snz_pend_q, snz_pend_d;

    // Snooze only from a non-edit state that is not being left for an edit
    assign snz_go   = bus.btn_stop & bus.Alarm & ~editing & ~edit_start;
    assign snz_fire = snz_pend_q & (stop_q == '0);

    always_comb begin
        snz_pend_d = snz_pend_q;
        if (snz_go) begin
            snz_pend_d = 1'b1;
        end else if (snz_fire || edit_start) begin
            snz_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snz_pend_q <= 1'b0;
        end else begin
            snz_pend_q <= snz_pend_d;
        end
    end
`else
    logic unused_alarm;
    assign unused_alarm = bus.Alarm;
    assign snz_go       = 1'b0;
    assign snz_fire     = 1'b0;
`endif

    assign bus.H_in1      = edit_q.h1;
    assign bus.H_in0      = edit_q.h0;
    assign bus.M_in1      = edit_q.m1;
    assign bus.M_in0      = edit_q.m0;
    assign bus.LD_time    = (state_q == COMMIT) && (tgt_q == TIME);
    assign bus.LD_alarm   = ((state_q == COMMIT) && (tgt_q == ALARM))
                          | snz_fire;
    assign bus.STOP_al    = (stop_q != '0);
    assign bus.AL_ON      = al_on_q;
    assign bus.editing    = editing;
    assign bus.edit_field = (state_q == EDIT_M);

endmodule

// File: tb/tb_aclk_set_ctrl.sv
// Self-checking bench for aclk_set_ctrl: directed steps then random
// button traffic against a minutes/hours reference model.
module tb_aclk_set_ctrl;

    localparam int T   = 300;
    localparam int SC  = 2;
    localparam int SNZ = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    aclk_set_ctrl_if bus ();

    aclk_set_ctrl #(
        .TIMEOUT_TICKS (T),
        .STOP_CYCLES   (SC),
        .SNOOZE_MIN    (SNZ)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    // stimulus
    bit b_st, b_sa, b_inc, b_nx, b_tog, b_stop, alarm;
    int th, tm;

    // model: md 0=idle 1=edit hours 2=edit minutes 3=commit
    int md, tg, vh, vm, sh, sm, idle_cnt, al, stop_left, pend;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        md = 0; tg = 0; vh = 0; vm = 0; sh = 0; sm = 0;
        idle_cnt = 0; al = 0; stop_left = 0; pend = 0;
    endtask

    function automatic bit snz_visible();
`ifdef ACLK_SNOOZE_EN
        return (pend != 0) && (stop_left == 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        int nmd;
        int win;
        bit any;
        bit fired;
        bit arm;
        int tot;
        nmd = md;
        any = b_st | b_sa | b_inc | b_nx | b_tog | b_stop;
        win = b_st ? 1 : b_sa ? 2 : b_nx ? 3 : b_inc ? 4 : b_tog ? 5 : 0;
        fired = snz_visible();
        case (md)
            0: begin
                if (win == 1) begin
                    nmd = 1; tg = 0; vh = th; vm = tm;
                end else if (win == 2) begin
                    nmd = 1; tg = 1; vh = sh; vm = sm;
                end else if (win == 5) begin
                    al = al ^ 1;
                end
            end
            1, 2: begin
                if (win == 3) nmd = md + 1;
                else if (win == 4 && md == 1) vh = (vh + 1) % 24;
                else if (win == 4) vm = (vm + 1) % 60;
                else if (!any && idle_cnt == T - 1) nmd = 0;
            end
            default: begin
                nmd = 0;
                if (tg == 1) begin
                    sh = vh; sm = vm;
                end
            end
        endcase
        if ((md == 1 || md == 2) && nmd == md && !any) idle_cnt++;
        else idle_cnt = 0;
        stop_left = b_stop ? SC : (stop_left > 0 ? stop_left - 1 : 0);
        arm = 1'b0;
`ifdef ACLK_SNOOZE_EN
        arm = b_stop && alarm && (md == 0 || md == 3) && (nmd == 0 || nmd == 3);
        if (arm) begin
            tot = (th * 60 + tm + SNZ) % 1440;
            vh = tot / 60;
            vm = tot % 60;
        end
`endif
        if (arm) pend = 1;
        else if (fired || (md == 0 && nmd == 1)) pend = 0;
        md = nmd;
    endtask

    task automatic drive();
        bus.btn_set_time  = b_st;
        bus.btn_set_alarm = b_sa;
        bus.btn_inc       = b_inc;
        bus.btn_next      = b_nx;
        bus.btn_al_toggle = b_tog;
        bus.btn_stop      = b_stop;
        bus.Alarm         = alarm;
        bus.H_out1        = 2'(th / 10);
        bus.H_out0        = 4'(th % 10);
        bus.M_out1        = 4'(tm / 10);
        bus.M_out0        = 4'(tm % 10);
    endtask

    task automatic check_all();
        chk("H_in1", 8'(bus.H_in1), 8'(vh / 10));
        chk("H_in0", 8'(bus.H_in0), 8'(vh % 10));
        chk("M_in1", 8'(bus.M_in1), 8'(vm / 10));
        chk("M_in0", 8'(bus.M_in0), 8'(vm % 10));
        chk("LD_time", 8'(bus.LD_time), 8'(md == 3 && tg == 0));
        chk("LD_alarm", 8'(bus.LD_alarm),
            8'((md == 3 && tg == 1) || snz_visible()));
        chk("STOP_al", 8'(bus.STOP_al), 8'(stop_left > 0));
        chk("AL_ON", 8'(bus.AL_ON), 8'(al));
        chk("editing", 8'(bus.editing), 8'(md == 1 || md == 2));
        chk("edit_field", 8'(bus.edit_field), 8'(md == 2));
    endtask

    task automatic cyc();
        drive();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        b_st = 0; b_sa = 0; b_inc = 0; b_nx = 0; b_tog = 0; b_stop = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        b_st = 0; b_sa = 0; b_inc = 0; b_nx = 0; b_tog = 0; b_stop = 0;
        alarm = 0; th = 0; tm = 0;
        drive();
        do_reset();
        cyc();

        // reset in the middle of a minute edit
        th = 7; tm = 45;
        b_st = 1; cyc();
        b_nx = 1; cyc();
        chk("t1_in_edit_m", 8'(bus.edit_field), 8'd1);
        do_reset();
        chk("t1_rst_edit", 8'(bus.editing), 8'd0);
        b_nx = 1; cyc();
        chk("t1_no_ldt", 8'(bus.LD_time), 8'd0);
        chk("t1_no_lda", 8'(bus.LD_alarm), 8'd0);

        // time edit 09:59 -> 10:01
        th = 9; tm = 59;
        b_st = 1; cyc();
        b_inc = 1; cyc();
        b_nx = 1; cyc();
        b_inc = 1; cyc();
        b_inc = 1; cyc();
        b_nx = 1; cyc();
        chk("t2_ldt", 8'(bus.LD_time), 8'd1);
        chk("t2_lda", 8'(bus.LD_alarm), 8'd0);
        chk("t2_h", {2'b0, bus.H_in1, bus.H_in0}, 8'h10);
        chk("t2_m", {bus.M_in1, bus.M_in0}, 8'h01);
        cyc();
        chk("t2_ldt_once", 8'(bus.LD_time), 8'd0);

        // alarm shadow to 23:59, then wrap to 00:00
        b_sa = 1; cyc();
        repeat (23) begin b_inc = 1; cyc(); end
        b_nx = 1; cyc();
        repeat (59) begin b_inc = 1; cyc(); end
        b_nx = 1; cyc();
        chk("t3_lda_2359", 8'(bus.LD_alarm), 8'd1);
        cyc();
        b_sa = 1; cyc();
        chk("t3_seed_h", {2'b0, bus.H_in1, bus.H_in0}, 8'h23);
        b_inc = 1; cyc();
        chk("t3_h_wrap", {2'b0, bus.H_in1, bus.H_in0}, 8'h00);
        b_nx = 1; cyc();
        b_inc = 1; cyc();
        chk("t3_m_wrap", {bus.M_in1, bus.M_in0}, 8'h00);
        chk("t3_h_keep", {2'b0, bus.H_in1, bus.H_in0}, 8'h00);
        b_nx = 1; cyc();
        chk("t3_lda", 8'(bus.LD_alarm), 8'd1);
        chk("t3_ldt", 8'(bus.LD_time), 8'd0);
        cyc();
        b_sa = 1; cyc();
        chk("t3_reseed", {bus.H_in0, bus.M_in0}, 8'h00);
        b_nx = 1; cyc();
        b_nx = 1; cyc();
        cyc();

        // timeout: full idle run aborts, inc at the last tick keeps editing
        b_st = 1; cyc();
        repeat (T - 1) cyc();
        chk("t4_still_edit", 8'(bus.editing), 8'd1);
        cyc();
        chk("t4_timeout", 8'(bus.editing), 8'd0);
        chk("t4_no_ld", 8'(bus.LD_time | bus.LD_alarm), 8'd0);
        b_st = 1; cyc();
        repeat (T - 1) cyc();
        b_inc = 1; cyc();
        chk("t4_inc_keeps", 8'(bus.editing), 8'd1);
        repeat (T - 1) cyc();
        chk("t4_restart", 8'(bus.editing), 8'd1);
        cyc();
        chk("t4_timeout2", 8'(bus.editing), 8'd0);

        // priority and alarm toggle
        th = 12; tm = 34;
        b_st = 1; b_inc = 1; cyc();
        chk("t5_prio_h", {2'b0, bus.H_in1, bus.H_in0}, 8'h12);
        chk("t5_prio_m", {bus.M_in1, bus.M_in0}, 8'h34);
        b_tog = 1; cyc();
        chk("t5_tog_edit", 8'(bus.AL_ON), 8'd0);
        b_nx = 1; cyc();
        b_nx = 1; cyc();
        cyc();
        b_tog = 1; cyc();
        chk("t5_tog_idle", 8'(bus.AL_ON), 8'd1);

        // stop with alarm ringing at 23:58
        th = 23; tm = 58; alarm = 1;
        b_stop = 1; cyc();
        chk("t6_stop1", 8'(bus.STOP_al), 8'd1);
        cyc();
        chk("t6_stop2", 8'(bus.STOP_al), 8'd1);
        cyc();
        chk("t6_stop_end", 8'(bus.STOP_al), 8'd0);
`ifdef ACLK_SNOOZE_EN
        chk("t6_snz_ld", 8'(bus.LD_alarm), 8'd1);
        chk("t6_snz_val", {bus.H_in0, bus.M_in0}, 8'h03);
`else
        chk("t6_no_ld", 8'(bus.LD_alarm), 8'd0);
`endif
        cyc();
        chk("t6_ld_once", 8'(bus.LD_alarm), 8'd0);
        alarm = 0;

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                th = $urandom_range(0, 23);
                tm = $urandom_range(0, 59);
            end
            alarm  = ($urandom_range(0, 2) == 0);
            b_st   = ($urandom_range(0, 19) == 0);
            b_sa   = ($urandom_range(0, 19) == 0);
            b_nx   = ($urandom_range(0, 5) == 0);
            b_inc  = ($urandom_range(0, 2) == 0);
            b_tog  = ($urandom_range(0, 9) == 0);
            b_stop = ($urandom_range(0, 11) == 0);
            cyc();
            if (i == 700) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
